// File: rtl/pcm_arb_pkg.sv
// Shared state encodings, client indices and the idle-state winner pick for pcm_mem_arbiter.
package pcm_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;

  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_B = 1'b1;

  // On a tie the client that was not served last wins.
  function automatic logic [1:0] idle_grant(input logic a_valid, input logic b_valid,
                                            input logic last_served);
    if (a_valid && (!b_valid || last_served == CLIENT_B)) return S_OWN_A;
    if (b_valid) return S_OWN_B;
    return S_IDLE;
  endfunction

endpackage

// File: rtl/pcm_arb_stats.sv
// Grant counters and worst-case grant wait for pcm_mem_arbiter (PCM_ARB_STATS_EN builds).
module pcm_arb_stats #(
  parameter int unsigned WAIT_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_grant,
  input  logic              b_grant,
  input  logic              a_waiting,
  input  logic              b_waiting,
  input  logic              a_done,
  input  logic              b_done,
  output logic [15:0]       a_grant_count,
  output logic [15:0]       b_grant_count,
  output logic [WAIT_W-1:0] max_wait
);

  logic [15:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [WAIT_W-1:0] a_wait_q, a_wait_d, b_wait_q, b_wait_d;
  logic [WAIT_W-1:0] max_wait_q, max_wait_d;

  always_comb begin
    a_cnt_d = a_cnt_q + 16'(a_done);
    b_cnt_d = b_cnt_q + 16'(b_done);

    a_wait_d = a_wait_q;
    if (a_grant) a_wait_d = '0;
    else if (a_waiting && a_wait_q != '1) a_wait_d = a_wait_q + WAIT_W'(1);

    b_wait_d = b_wait_q;
    if (b_grant) b_wait_d = '0;
    else if (b_waiting && b_wait_q != '1) b_wait_d = b_wait_q + WAIT_W'(1);

    // Wait value sampled is the one accumulated up to the grant cycle.
    max_wait_d = max_wait_q;
    if (a_grant && a_wait_q > max_wait_d) max_wait_d = a_wait_q;
    if (b_grant && b_wait_q > max_wait_d) max_wait_d = b_wait_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_cnt_q    <= '0;
      b_cnt_q    <= '0;
      a_wait_q   <= '0;
      b_wait_q   <= '0;
      max_wait_q <= '0;
    end else begin
      a_cnt_q    <= a_cnt_d;
      b_cnt_q    <= b_cnt_d;
      a_wait_q   <= a_wait_d;
      b_wait_q   <= b_wait_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign a_grant_count = a_cnt_q;
  assign b_grant_count = b_cnt_q;
  assign max_wait      = max_wait_q;

endmodule

// File: rtl/pcm_mem_arbiter.sv
// Round-robin arbiter for the shared PCM memory port between ADPCM-A and ADPCM-B readers.
// Define PCM_ARB_STATS_EN to add grant counters and max-wait statistics.
module pcm_mem_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned WAIT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_mem_addr,
  input  logic              a_mem_valid,
  output logic              a_mem_ready,
  output logic [7:0]        a_mem_rdata,
  input  logic [ADDR_W-1:0] b_mem_addr,
  input  logic              b_mem_valid,
  output logic              b_mem_ready,
  output logic [7:0]        b_mem_rdata,
  output logic [ADDR_W-1:0] pcm_mem_addr,
  output logic              pcm_mem_valid,
  input  logic [7:0]        pcm_mem_rdata,
  input  logic              pcm_mem_ready,
  output logic              busy
`ifdef PCM_ARB_STATS_EN
  ,
  input  logic              stats_reset,
  output logic [15:0]       a_grant_count,
  output logic [15:0]       b_grant_count,
  output logic [WAIT_W-1:0] max_wait
`endif
);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] idle_win, sel;

  always_comb begin
    idle_win      = idle_grant(a_mem_valid, b_mem_valid, last_q);
    sel           = (state_q == S_IDLE) ? idle_win : state_q;
    state_d       = state_q;
    last_d        = last_q;
    pcm_mem_addr  = '0;
    pcm_mem_valid = 1'b0;
    a_mem_ready   = 1'b0;
    b_mem_ready   = 1'b0;

    // Same-cycle forwarding: in idle the freshly picked winner drives memory.
    unique case (sel)
      S_OWN_A: begin
        pcm_mem_addr  = a_mem_addr;
        pcm_mem_valid = a_mem_valid;
      end
      S_OWN_B: begin
        pcm_mem_addr  = b_mem_addr;
        pcm_mem_valid = b_mem_valid;
      end
      default: ;
    endcase

    unique case (state_q)
      S_IDLE: state_d = idle_win;
      S_OWN_A: begin
        a_mem_ready = pcm_mem_ready & ~reset;
        if (pcm_mem_ready) begin
          last_d  = CLIENT_A;
          state_d = S_IDLE;
        end else if (!a_mem_valid) begin
          state_d = S_IDLE;
        end
      end
      S_OWN_B: begin
        b_mem_ready = pcm_mem_ready & ~reset;
        if (pcm_mem_ready) begin
          last_d  = CLIENT_B;
          state_d = S_IDLE;
        end else if (!b_mem_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= CLIENT_B;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign a_mem_rdata = pcm_mem_rdata;
  assign b_mem_rdata = pcm_mem_rdata;

`ifdef PCM_ARB_STATS_EN
  logic a_grant, b_grant;
  assign a_grant = (state_q == S_IDLE) && (idle_win == S_OWN_A);
  assign b_grant = (state_q == S_IDLE) && (idle_win == S_OWN_B);

  pcm_arb_stats #(
    .WAIT_W(WAIT_W)
  ) u_stats (
    .clk          (clk),
    .clr          (reset | stats_reset),
    .a_grant      (a_grant),
    .b_grant      (b_grant),
    .a_waiting    (a_mem_valid && state_q != S_OWN_A && !a_grant),
    .b_waiting    (b_mem_valid && state_q != S_OWN_B && !b_grant),
    .a_done       (a_mem_ready),
    .b_done       (b_mem_ready),
    .a_grant_count(a_grant_count),
    .b_grant_count(b_grant_count),
    .max_wait     (max_wait)
  );
`else
  logic [WAIT_W-1:0] unused_wait_w;
  assign unused_wait_w = '0;
`endif

endmodule

// File: doc/pcm_mem_arbiter.md
# pcm_mem_arbiter

Two-requester arbiter sharing the single PCM sample memory port between the ADPCM-A and ADPCM-B reader channels. Sits between the readers' `pcm_mem_*` valid/ready ports and the board-level PCM memory controller. The current winner's request is forwarded with zero added latency. Simultaneous requests are resolved round-robin, so neither YM2610 PMPX-driven read can starve.

## Interface

Parameters:
- `ADDR_W`, 24, PCM byte-address width.
- `WAIT_W`, 8, width of the wait-cycle counters (stats build only).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `a_mem_addr`  in  ADDR_W  ADPCM-A request address; held stable while `a_mem_valid`.
- `a_mem_valid`  in  1  ADPCM-A request; held until `a_mem_ready`.
- `a_mem_ready`  out  1  one-cycle completion strobe to ADPCM-A.
- `a_mem_rdata`  out  8  data to ADPCM-A; valid when `a_mem_ready`.
- `b_mem_addr`, `b_mem_valid`, `b_mem_ready`, `b_mem_rdata`: same as above, for ADPCM-B.
- `pcm_mem_addr`  out  ADDR_W  address to memory.
- `pcm_mem_valid`  out  1  request to memory.
- `pcm_mem_rdata`  in  8  memory read data.
- `pcm_mem_ready`  in  1  memory completion strobe.
- `busy`  out  1  high while a client owns the port.
- `stats_reset`  in  1  clears the statistics (stats build only).
- `a_grant_count`, `b_grant_count`  out  16  completed transactions per client (stats build only).
- `max_wait`  out  WAIT_W  worst observed grant wait, either client (stats build only).

## Operation

- State machine `S_IDLE`, `S_OWN_A`, `S_OWN_B`. `last_served` is a 1-bit register that resets to B, so A wins the first tie.

S_IDLE:
- Winner selection:
  - only A valid → A;
  - only B valid → B;
  - both valid → client ≠ `last_served`.
- The winner's `addr` and `valid` drive `pcm_mem_addr`/`pcm_mem_valid` combinationally in the same cycle.
- Next state is `S_OWN_<winner>`.
- No valid: `pcm_mem_valid`=0, `pcm_mem_addr`=0.

S_OWN_x:
- Owner's addr/valid are forwarded.
- `pcm_mem_ready` is routed only to the owner's `x_mem_ready`.
- `pcm_mem_rdata` is broadcast to both `x_mem_rdata`. Only the strobed client samples it.
- On `pcm_mem_ready`: `last_served`←x, next state `S_IDLE`.
- If the owner drops valid without ready (protocol violation): next state `S_IDLE`, `last_served` unchanged, no ready issued.

Other rules:
- `pcm_mem_ready` received in `S_IDLE` is ignored. The memory contract is that ready follows valid by ≥1 cycle.
- The non-owner's `valid` never reaches memory. Its ready stays 0 until it is granted.
- `busy` = (state ≠ `S_IDLE`).
- Reset mid-transaction:
  - next cycle is `S_IDLE`;
  - all readys 0;
  - `pcm_mem_valid` follows the IDLE rule;
  - `last_served`=B;
  - any outstanding memory response is ignored.

## Timing

- Grant latency: 0 cycles. A request seen in `S_IDLE` appears on `pcm_mem_valid` the same cycle.
- Back-to-back handoff:
  - ready to A in cycle N;
  - `S_IDLE` in N+1;
  - B forwarded in N+1.
  - This gives one idle-free cycle, with no bubble on `pcm_mem_valid` when B is pending.
- Completion: `x_mem_ready` = `pcm_mem_ready` in the same cycle, purely combinational, no added register.
- Outputs after reset: `pcm_mem_valid` 0, `pcm_mem_addr` 0, `a_/b_mem_ready` 0, `busy` 0, all counters 0.

## Configuration

- `PCM_ARB_STATS_EN` defined:
  - stats ports and counters exist.
  - Grant counters increment on each routed ready and wrap at 16 bits.
  - Each per-client wait counter counts cycles with valid high while not owner. It saturates at all-ones and clears on grant.
  - `max_wait` latches the larger of itself and either wait counter at grant.
  - `reset` or `stats_reset` clears all counters.
- Undefined: stats ports are absent; arbitration behaviour is identical.

## Structure

- `pcm_arb_pkg`:
  - state encodings `S_IDLE`/`S_OWN_A`/`S_OWN_B`;
  - client index constants `CLIENT_A`=0, `CLIENT_B`=1.
- Sub-module `pcm_arb_stats` holds the counters and `max_wait`. It is instantiated only under `PCM_ARB_STATS_EN`.

## Test plan

- **Single client:** A valid, addr 0x012345. Memory ready 3 cycles later with rdata 0xA5. Required: `pcm_mem_addr`=0x012345 the same cycle; `a_mem_ready` pulses with rdata 0xA5; `b_mem_ready` stays 0; `busy` 1→0.
- **Tie after reset:** A and B valid in the same cycle. Required: A granted first, then B in the cycle after A's ready. A second tie then grants A again (B was last served).
- **Back-to-back:** B requests while A owns the port. Required: B addr on memory exactly 1 cycle after A's ready; `b_grant_count`=1 afterwards (stats build).
- **Reset mid-transaction:** reset asserted while `S_OWN_B`, ready arrives 1 cycle after reset deasserts. Required: ready ignored; no `b_mem_ready`; `busy`=0.
- **Owner abort:** A drops valid with no ready. Required: `S_IDLE` next cycle; a pending B is granted in that cycle.
- **Wait stats:** B held waiting 300 cycles with `WAIT_W`=8. Required: `max_wait`=255 (saturated); `stats_reset` returns it to 0.
